// File: rtl/ovl_always_on_edge_window.sv
// Multi-channel always-on-edge checker: each qualifying sampling edge must see test_expr
// high in the edge cycle or within WINDOW following cycles, else the channel fires.
module ovl_always_on_edge_window #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned EDGE_TYPE = 1,
  parameter int unsigned WINDOW    = 0,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned COVER_EN  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    sampling_event,
  input  logic [NUM_CH-1:0]    test_expr,
  input  logic                 clear,
  output logic [NUM_CH-1:0]    fire_assert,
  output logic [NUM_CH-1:0]    fire_cover,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    sticky,
  output logic [CNT_WIDTH-1:0] viol_count
);

  localparam int unsigned REM_W = 4;
  localparam int unsigned SUM_W = CNT_WIDTH + 6;
  localparam logic [REM_W-1:0]     WIN_INIT = REM_W'(WINDOW);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [REM_W-1:0]  rem_q   [NUM_CH];
  logic [REM_W-1:0]  rem_d   [NUM_CH];

  logic [NUM_CH-1:0]    se_prev_q;
  logic                 prev_valid_q;
  logic [NUM_CH-1:0]    edge_raw;
  logic [NUM_CH-1:0]    edge_c;
  logic [NUM_CH-1:0]    viol_c;
  logic [NUM_CH-1:0]    busy_d;
  logic [NUM_CH-1:0]    sticky_d;
  logic [CNT_WIDTH-1:0] count_base;
  logic [SUM_W-1:0]     count_sum;
  logic [CNT_WIDTH-1:0] count_d;

  logic [NUM_CH-1:0]    fire_assert_q;
  logic [NUM_CH-1:0]    fire_cover_q;
  logic [NUM_CH-1:0]    busy_q;
  logic [NUM_CH-1:0]    sticky_q;
  logic [CNT_WIDTH-1:0] count_q;

  // Qualifying edge, suppressed until a valid previous sample exists
  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      32'd0:   edge_raw = sampling_event;
      32'd1:   edge_raw = sampling_event & ~se_prev_q;
      32'd2:   edge_raw = ~sampling_event & se_prev_q;
      default: edge_raw = sampling_event ^ se_prev_q;
    endcase
    edge_c = edge_raw & {NUM_CH{prev_valid_q & enable}};
  end

  // Per-channel window FSM next state and violation detect
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      viol_c[i]  = 1'b0;
      if (!enable) begin
        state_d[i] = IDLE;
        rem_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (edge_c[i] && !test_expr[i]) begin
              if (WINDOW == 0) begin
                viol_c[i] = 1'b1;
              end else begin
                state_d[i] = WAIT;
                rem_d[i]   = WIN_INIT;
              end
            end
          end
          WAIT: begin
            if (test_expr[i]) begin
              state_d[i] = IDLE;
              rem_d[i]   = '0;
            end else if (rem_q[i] == REM_W'(1)) begin
              viol_c[i]  = 1'b1;
              state_d[i] = IDLE;
              rem_d[i]   = '0;
            end else begin
              rem_d[i] = REM_W'(rem_q[i] - REM_W'(1));
            end
          end
          default: begin
            state_d[i] = IDLE;
            rem_d[i]   = '0;
          end
        endcase
      end
      busy_d[i] = (state_d[i] == WAIT);
    end
  end

  // Clear zeroes the base first so a coincident violation still lands
  always_comb begin
    sticky_d   = (clear ? '0 : sticky_q) | viol_c;
    count_base = clear ? '0 : count_q;
    count_sum  = SUM_W'(count_base) + SUM_W'($countones(viol_c));
    count_d    = (count_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(count_sum);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      se_prev_q     <= '0;
      prev_valid_q  <= 1'b0;
      fire_assert_q <= '0;
      fire_cover_q  <= '0;
      busy_q        <= '0;
      sticky_q      <= '0;
      count_q       <= '0;
    end else begin
      se_prev_q     <= sampling_event;
      prev_valid_q  <= 1'b1;
      fire_assert_q <= viol_c;
      fire_cover_q  <= (COVER_EN != 0) ? edge_c : '0;
      busy_q        <= busy_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
    end
  end

  assign fire_assert = fire_assert_q;
  assign fire_cover  = fire_cover_q;
  assign busy        = busy_q;
  assign sticky      = sticky_q;
  assign viol_count  = count_q;

endmodule

// File: doc/ovl_always_on_edge_window.md
Name: ovl_always_on_edge_window

Overview:
Multi-channel, parametrised successor to the single-channel always-on-edge checker.
- Each channel watches its own sampling_event. Edge type is selectable.
- On a qualifying edge, the channel's test_expr must be high in the edge cycle or within WINDOW following cycles. Otherwise the channel fires.
- Adds per-channel cover pulses, sticky violation flags and a shared saturating violation counter.
- Sits beside the fabric's other OVL checkers; its outputs feed the assertion status collector.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
EDGE_TYPE, 1, qualifying edge: 0 = level (every cycle with sampling_event high), 1 = rising, 2 = falling, 3 = any edge
WINDOW, 0, extra cycles after the edge during which test_expr may satisfy the check (0..15; 0 = same-cycle check only)
CNT_WIDTH, 8, width of viol_count
COVER_EN, 1, 1 = drive fire_cover; 0 = tie fire_cover to 0

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  global check enable
sampling_event  in  NUM_CH  per-channel sampling signal
test_expr  in  NUM_CH  per-channel expression under check
clear  in  1  synchronous clear of sticky and viol_count
fire_assert  out  NUM_CH  one-cycle violation pulse per channel
fire_cover  out  NUM_CH  one-cycle pulse per qualifying edge
busy  out  NUM_CH  channel is in WAIT
sticky  out  NUM_CH  latched violation flag per channel
viol_count  out  CNT_WIDTH  saturating total of violations

Behaviour:
- Reset: reset is synchronous and active-high. While reset is high at a clock edge:
  - every output is cleared to 0;
  - sampling_event_prev is cleared to 0;
  - prev_valid is cleared to 0;
  - all channels go to IDLE.
- prev_valid: set to 1 on the first clock after reset is low. No edge is detected while prev_valid = 0, so no spurious edge occurs in the first post-reset cycle.
- Edge detection per channel i, with prev = sampling_event_prev[i] (registered every cycle regardless of enable):
  - EDGE_TYPE 0: se
  - EDGE_TYPE 1: se & ~prev
  - EDGE_TYPE 2: ~se & prev
  - EDGE_TYPE 3: se ^ prev
  - In all cases the result is ANDed with prev_valid and with enable.
- Per-channel FSM, states IDLE and WAIT, with a 4-bit remaining-cycle counter rem:
  - IDLE, edge, test_expr high: pass; stay IDLE.
  - IDLE, edge, test_expr low, WINDOW = 0: violation; stay IDLE.
  - IDLE, edge, test_expr low, WINDOW > 0: go to WAIT with rem = WINDOW.
  - WAIT, test_expr high: pass; go to IDLE.
  - WAIT, test_expr low, rem > 1: rem decrements.
  - WAIT, test_expr low, rem = 1: violation; go to IDLE.
  - New edges during WAIT do not re-arm or restart the window. They still produce fire_cover.
  - enable low forces IDLE and rem = 0 on the next clock, with no violation. A pending window is abandoned.
- Violation pulses and latency:
  - A violation detected in cycle t gives fire_assert[i] = 1 in cycle t+1 only.
  - The same-cycle check therefore has latency 1. A timed-out window fires the cycle after the last window cycle.
  - fire_cover[i] = 1 in cycle t+1 for an edge in cycle t (only if COVER_EN = 1).
- sticky[i]: set in the same cycle fire_assert[i] rises; held until clear or reset.
- viol_count: on each clock, next = sat(current + popcount of the violations being registered).
- clear: if high, sticky and count start from 0 before that cycle's violations are applied. A coincident violation therefore wins: count = popcount and the matching sticky bits are set.
- Saturation: viol_count stays at 2^CNT_WIDTH-1 and never wraps. Multi-channel increments clamp.
- busy[i] is a registered copy of state == WAIT.
- Channels are fully independent. Simultaneous violations on all channels in one cycle are all reported.
- Reset mid-WAIT: the window is abandoned and no fire is produced.

Test Plan:
- NUM_CH = 1, EDGE_TYPE = 1, WINDOW = 0: se 0→1 with te = 0 in cycle 10 → fire_assert = 1 in cycle 11 only, sticky = 1, viol_count = 1. The same stimulus with te = 1 → no fire.
- Post-reset: se held at 1 through reset release → no fire_cover and no fire_assert. Then a 0→1 edge → fire_cover pulse 1 cycle later.
- WINDOW = 3: rising edge with te = 0 → busy = 1 for 3 cycles. te = 1 in the 2nd window cycle → no fire, busy drops. With te held 0 → fire_assert exactly 4 cycles after the edge. A second edge during WAIT does not extend the window.
- NUM_CH = 4, EDGE_TYPE = 3, CNT_WIDTH = 2: violations on all 4 channels in the same cycle → fire_assert = 4'b1111, viol_count = 3 (saturated). A further violation keeps viol_count = 3.
- clear asserted in the same cycle a channel-2 violation is registered → sticky = 4'b0100, viol_count = 1.
- enable dropped mid-WAIT → channel goes to IDLE next clock, no fire. Synchronous reset asserted mid-WAIT → all outputs 0 on the next clock, no fire after release.
